// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared FSM states, NOP encoding and FIFO depth for the fetch unit
package fetch_unit_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DROP} state_e;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int FIFO_DEPTH = 2;
endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: small in-order FIFO of fetched {pc, instr} pairs with synchronous clear
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         clear_i,
    input  logic [W-1:0] din_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    logic [W-1:0]  mem_q [FIFO_DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;
    // storage needs no reset; occupancy tracking decides what is valid
    always_ff @(posedge clk)
        if (push_i) mem_q[wr_q] <= din_i;
    // pointers and occupancy; clear wins over push/pop
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (clear_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + PW'(1);
            if (pop_i) rd_q <= rd_q + PW'(1);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    assign full_o  = cnt_q == CW'(FIFO_DEPTH);
    assign empty_o = cnt_q == '0;
    assign head_o  = mem_q[rd_q];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with one outstanding request, 2-entry buffer and redirect; FETCH_PERF_COUNT_EN adds fetch_count
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall_f,
    input  logic                     flush_f,
    input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic                     imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]    imem_rsp_data,
    output logic [ADDRESS_WIDTH-1:0] pc_f,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
    output logic [DATA_WIDTH-1:0]    instr_f,
    output logic                     valid_f
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [31:0]              fetch_count
`endif
);
    localparam int AW = ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;
    state_e         state_q, state_d;
    logic [AW-1:0]  fpc_q, fpc_d;
    logic           full, empty, pop, push;
    logic [AW+DW-1:0] head;
    logic [AW-1:0]  target;
    assign target = {pc_target_e[AW-1:2], 2'b00};
    assign pop    = !empty && !stall_f && !flush_f;
    // state and fetch PC registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            fpc_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
        end
    // request issue, response capture and redirect sequencing
    always_comb begin
        state_d        = state_q;
        fpc_d          = fpc_q;
        imem_req_valid = 1'b0;
        push           = 1'b0;
        case (state_q)
            IDLE: state_d = ISSUE;
            ISSUE: begin
                imem_req_valid = !full || pop;
                if (imem_req_valid && imem_req_ready) begin
                    fpc_d   = fpc_q + AW'(4);
                    state_d = flush_f ? DROP : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                push    = imem_rsp_valid && !flush_f;
                state_d = imem_rsp_valid ? ISSUE : flush_f ? DROP : WAIT_RSP;
            end
            DROP: state_d = imem_rsp_valid ? ISSUE : DROP;
            default: state_d = IDLE;
        endcase
        if (flush_f) fpc_d = target;
    end
    // the only outstanding request was made at fpc-4, so the response's pc is derived
    fetch_fifo #(.W(AW + DW)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (push),
        .pop_i  (pop),
        .clear_i(flush_f),
        .din_i  ({fpc_q - AW'(4), imem_rsp_data}),
        .full_o (full),
        .empty_o(empty),
        .head_o (head)
    );
    assign imem_addr  = fpc_q;
    assign valid_f    = !empty;
    assign pc_f       = empty ? fpc_q : head[AW+DW-1:DW];
    assign instr_f    = empty ? DW'(NOP_INSTR) : head[DW-1:0];
    assign pc_plus4_f = pc_f + AW'(4);
`ifdef FETCH_PERF_COUNT_EN
    logic [31:0] fetch_count_q;
    // counts instructions handed to decode
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) fetch_count_q <= '0;
        else if (pop) fetch_count_q <= fetch_count_q + 32'd1;
    assign fetch_count = fetch_count_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_f, flush_f;
    logic [31:0] pc_target_e;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] pc_f, pc_plus4_f, instr_f;
    logic        valid_f;
`ifdef FETCH_PERF_COUNT_EN
    logic [31:0] fetch_count;
`endif
    int checks = 0;
    int failures = 0;
    logic auto = 1'b1;

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_f       (stall_f),
        .flush_f       (flush_f),
        .pc_target_e   (pc_target_e),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .pc_f          (pc_f),
        .pc_plus4_f    (pc_plus4_f),
        .instr_f       (instr_f),
        .valid_f       (valid_f)
`ifdef FETCH_PERF_COUNT_EN
        ,
        .fetch_count   (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    // one clock; memory model answers one cycle after an accept with data = ~addr
    task automatic step();
        logic hs;
        logic [31:0] a;
        @(negedge clk);
        hs = imem_req_valid && imem_req_ready;
        a = imem_addr;
        @(posedge clk);
        #1;
        if (auto) begin
            imem_rsp_valid = hs;
            imem_rsp_data = ~a;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall_f = 1'b0;
        flush_f = 1'b0;
        pc_target_e = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall_f = 1'b0;
        flush_f = 1'b0;
        pc_target_e = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        #2;
        if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%h exp=0", imem_req_valid); end
        checks++;
        if (valid_f !== 1'b0) begin failures++; $display("FAIL rst_valid_f got=%h exp=0", valid_f); end
        checks++;
        if (instr_f !== 32'h13) begin failures++; $display("FAIL rst_instr got=%h exp=00000013", instr_f); end
        checks++;
        if (pc_f !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", pc_f); end
        checks++;
        if (pc_plus4_f !== 32'h4) begin failures++; $display("FAIL rst_pc4 got=%h exp=4", pc_plus4_f); end
        checks++;
    endtask

    task automatic test_first_fetch();
        do_reset();
        step();
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL first_req got=%h/%h exp=1/0", imem_req_valid, imem_addr); end
        checks++;
        step();
        if (imem_req_valid !== 1'b0 || valid_f !== 1'b0) begin failures++; $display("FAIL first_wait got=%h/%h exp=0/0", imem_req_valid, valid_f); end
        checks++;
        step();
        if (valid_f !== 1'b1 || pc_f !== 32'h0 || pc_plus4_f !== 32'h4) begin failures++; $display("FAIL first_valid got=%h/%h/%h exp=1/0/4", valid_f, pc_f, pc_plus4_f); end
        checks++;
        if (instr_f !== 32'hFFFF_FFFF) begin failures++; $display("FAIL first_instr got=%h exp=ffffffff", instr_f); end
        checks++;
    endtask

    task automatic test_stall();
        do_reset();
        stall_f = 1'b1;
        repeat (4) step();
        for (int i = 0; i < 4; i++) begin
            if (imem_req_valid !== 1'b0 || valid_f !== 1'b1 || pc_f !== 32'h0 || instr_f !== 32'hFFFF_FFFF) begin
                failures++;
                $display("FAIL stall_hold[%0d] got req=%h v=%h pc=%h instr=%h exp 0/1/0/ffffffff", i, imem_req_valid, valid_f, pc_f, instr_f);
            end
            checks++;
            step();
        end
        stall_f = 1'b0;
        #1;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL stall_release_req got=%h/%h exp=1/8", imem_req_valid, imem_addr); end
        checks++;
        step();
        if (pc_f !== 32'h4 || instr_f !== ~32'h4) begin failures++; $display("FAIL pop_order1 got=%h/%h exp=4/fffffffb", pc_f, instr_f); end
        checks++;
        step();
        if (pc_f !== 32'h8 || valid_f !== 1'b1) begin failures++; $display("FAIL pop_order2 got=%h/%h exp=8/1", pc_f, valid_f); end
        checks++;
        flush_f = 1'b1;
        pc_target_e = 32'h40;
        step();
        flush_f = 1'b0;
        if (valid_f !== 1'b0 || pc_f !== 32'h40) begin failures++; $display("FAIL flush_clear got=%h/%h exp=0/40", valid_f, pc_f); end
        checks++;
        step();
        if (valid_f !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h40) begin failures++; $display("FAIL flush_drop_issue got=%h/%h/%h exp=0/1/40", valid_f, imem_req_valid, imem_addr); end
        checks++;
    endtask

    task automatic test_flush_wait();
        do_reset();
        auto = 1'b0;
        step();
        step();
        flush_f = 1'b1;
        pc_target_e = 32'h103;
        step();
        flush_f = 1'b0;
        if (imem_req_valid !== 1'b0 || pc_f !== 32'h100) begin failures++; $display("FAIL drop_state got=%h/%h exp=0/100", imem_req_valid, pc_f); end
        checks++;
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid = 1'b0;
        if (valid_f !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL drop_discard got=%h/%h/%h exp=0/1/100", valid_f, imem_req_valid, imem_addr); end
        checks++;
        auto = 1'b1;
        step();
        step();
        if (valid_f !== 1'b1 || pc_f !== 32'h100 || instr_f !== ~32'h100) begin failures++; $display("FAIL redirect_first got=%h/%h/%h exp=1/100/fffffeff", valid_f, pc_f, instr_f); end
        checks++;
    endtask

    task automatic test_flush_rsp();
        do_reset();
        stall_f = 1'b1;
        step();
        step();
        flush_f = 1'b1;
        pc_target_e = 32'h200;
        step();
        flush_f = 1'b0;
        if (valid_f !== 1'b0 || instr_f !== 32'h13 || pc_f !== 32'h200) begin failures++; $display("FAIL flush_rsp_empty got=%h/%h/%h exp=0/13/200", valid_f, instr_f, pc_f); end
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL flush_rsp_req got=%h/%h exp=1/200", imem_req_valid, imem_addr); end
        checks++;
        stall_f = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        stall_f = 1'b1;
        flush_f = 1'b1;
        pc_target_e = 32'hFFFF_FFFC;
        step();
        flush_f = 1'b0;
        if (imem_addr !== 32'hFFFF_FFFC || pc_plus4_f !== 32'h0) begin failures++; $display("FAIL wrap_fpc got=%h/%h exp=fffffffc/0", imem_addr, pc_plus4_f); end
        checks++;
        step();
        step();
        if (pc_f !== 32'hFFFF_FFFC || pc_plus4_f !== 32'h0 || instr_f !== 32'h3) begin failures++; $display("FAIL wrap_head got=%h/%h/%h exp=fffffffc/0/3", pc_f, pc_plus4_f, instr_f); end
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_next_req got=%h/%h exp=1/0", imem_req_valid, imem_addr); end
        checks++;
        stall_f = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        auto = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        if (imem_req_valid !== 1'b0 || valid_f !== 1'b0 || pc_f !== 32'h0) begin failures++; $display("FAIL async_rst got=%h/%h/%h exp=0/0/0", imem_req_valid, valid_f, pc_f); end
        checks++;
        step();
        rst_n = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'h1234_5678;
        step();
        imem_rsp_valid = 1'b0;
        if (valid_f !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL idle_ignore got=%h/%h/%h exp=0/1/0", valid_f, imem_req_valid, imem_addr); end
        checks++;
        auto = 1'b1;
    endtask

`ifdef FETCH_PERF_COUNT_EN
    task automatic test_perf();
        logic found;
        do_reset();
        if (fetch_count !== 32'h0) begin failures++; $display("FAIL perf_reset got=%h exp=0", fetch_count); end
        checks++;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            stall_f = (i == 3 || i == 7 || i == 11);
            step();
            if (valid_f && pc_f == 32'h28) found = 1'b1;
        end
        stall_f = 1'b0;
        if (!found || fetch_count !== 32'd10) begin failures++; $display("FAIL perf_count got=%0d found=%0d exp=10/1", fetch_count, found); end
        checks++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_flush_wait();
        test_flush_rsp();
        test_wrap();
        test_reset_mid();
`ifdef FETCH_PERF_COUNT_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
